// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared MIPS definitions: opcodes, fetch FSM states, helpers
package instruction_fetch_unit_pkg;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;

   typedef enum logic [1:0] {
      S_REQ   = 2'b00,
      S_WAIT  = 2'b01,
      S_ISSUE = 2'b10
   } fetch_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// rtl/instruction_fetch_unit_next_pc_calc.sv - combinational next-PC: sequential, taken BEQ, or J
module next_pc_calc
   import instruction_fetch_unit_pkg::*;
(
   input  logic [31:0] PC,
   input  logic [31:0] Instruction,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Zero,
   output logic [31:0] NextPC
);

   logic [31:0] pc4;
   logic [31:0] br_off;
   logic [31:0] jmp_tgt;
   logic [31:0] raw_next;
   logic        unused_opcode;

   assign pc4     = PC + 32'd4;
   assign br_off  = {{14{Instruction[15]}}, Instruction[15:0], 2'b00};
   assign jmp_tgt = {pc4[31:28], Instruction[25:0], 2'b00};

   // the opcode field is decoded upstream; only the immediate fields matter here
   assign unused_opcode = ^Instruction[31:26];

   always_comb begin
      raw_next = pc4;
      if (Jump)
         raw_next = jmp_tgt;
      else if (Branch && Zero)
         raw_next = pc4 + br_off;
      NextPC = word_align(raw_next);
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - REQ/WAIT/ISSUE fetch FSM holding one instruction until retire
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        Reset_L,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] Instruction,
   output logic [5:0]  Opcode,
   output logic        instr_valid,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Zero,
   input  logic        retire,
   output logic [31:0] PC,
   output logic [31:0] fetch_count,
   output logic [31:0] redirect_count
);

   fetch_state_t state;
   logic [31:0]  next_pc;

   next_pc_calc u_next_pc (
      .PC          (PC),
      .Instruction (Instruction),
      .Branch      (Branch),
      .Jump        (Jump),
      .Zero        (Zero),
      .NextPC      (next_pc)
   );

   // gated by Reset_L so the request drops during reset and rises in the first released cycle
   assign imem_req_valid = Reset_L && (state == S_REQ);
   assign imem_addr      = PC;
   assign Opcode         = Instruction[31:26];

   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         state       <= S_REQ;
         PC          <= word_align(RESET_PC);
         Instruction <= '0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (imem_req_ready)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  Instruction <= imem_rsp_data;
                  instr_valid <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (retire) begin
                  PC          <= next_pc;
                  instr_valid <= 1'b0;
                  state       <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] redirect_cnt_q;
   logic        redirect_taken;

   assign redirect_taken = Jump || (Branch && Zero);

   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         fetch_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (state == S_WAIT && imem_rsp_valid)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (state == S_ISSUE && retire && redirect_taken)
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
   end

   assign fetch_count    = fetch_cnt_q;
   assign redirect_count = redirect_cnt_q;
`else
   assign fetch_count    = '0;
   assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench: directed next-PC cases, reset abort, random traffic
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        CLK = 1'b0;
   logic        Reset_L;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] Instruction;
   logic [5:0]  Opcode;
   logic        instr_valid;
   logic        Branch, Jump, Zero, retire;
   logic [31:0] PC;
   logic [31:0] fetch_count, redirect_count;

   instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .CLK            (CLK),
      .Reset_L        (Reset_L),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .Instruction    (Instruction),
      .Opcode         (Opcode),
      .instr_valid    (instr_valid),
      .Branch         (Branch),
      .Jump           (Jump),
      .Zero           (Zero),
      .retire         (retire),
      .PC             (PC),
      .fetch_count    (fetch_count),
      .redirect_count (redirect_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] fc;
      logic [31:0] rc;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] nxt;
      bit          b;
      bit          j;
      bit          z;
      int          stall;
   } dstep_t;

   exp_t        exp_iq[$];
   logic [31:0] exp_aq[$];
   dstep_t      dir[11];

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          rel_cyc = 0;
   bit          lat_check = 0;
   bit          rst_seen = 0;
   logic [31:0] m_pc, m_fc, m_rc;

   always @(posedge CLK) begin
      cyc++;
      rst_seen = !Reset_L;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                              input bit b, input bit j, input bit z);
      logic [31:0] pc4;
      int          off;
      pc4 = pc + 32'd4;
      if (j)
         return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
      if (b && z) begin
         off = $signed(instr[15:0]);
         return pc4 + 32'(off * 4);
      end
      return pc4;
   endfunction

   function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
      return v;
`else
      return (v & 32'h0);
`endif
   endfunction

   task automatic do_step(input logic [31:0] instr, input bit b, input bit j, input bit z,
                          input int stall, input int rsp_dly, input int iss_dly,
                          input bit use_exp, input logic [31:0] exp_next);
      bit          hs;
      int          n;
      logic [31:0] nxt;
      hs = 0;
      n  = 0;
      while (!hs && n < 60) begin
         if (stall >= 0)
            imem_req_ready = (n >= stall);
         else
            imem_req_ready = ($urandom_range(0, 2) != 0);
         if (stall < 0 && $urandom_range(0, 3) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
         end else begin
            imem_rsp_valid = 1'b0;
         end
         @(negedge CLK);
         hs = imem_req_valid && imem_req_ready;
         tick();
         n++;
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      if (!hs) begin
         n_cmp++;
         n_err++;
         $display("FAIL req_timeout: no request handshake, expected addr %h", m_pc);
         return;
      end
      repeat (rsp_dly) tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr;
      m_fc = m_fc + 32'd1;
      exp_iq.push_back('{instr, m_pc, exp_cnt(m_fc), exp_cnt(m_rc)});
      tick();
      imem_rsp_valid = 1'b0;
      repeat (iss_dly) begin
         Branch = 1'($urandom_range(0, 1));
         Jump   = 1'($urandom_range(0, 1));
         Zero   = 1'($urandom_range(0, 1));
         imem_rsp_valid = 1'($urandom_range(0, 1));
         imem_rsp_data  = $urandom;
         tick();
      end
      imem_rsp_valid = 1'b0;
      Branch = b;
      Jump   = j;
      Zero   = z;
      retire = 1'b1;
      nxt = model_next(m_pc, instr, b, j, z);
      if (j || (b && z))
         m_rc = m_rc + 32'd1;
      m_pc = nxt;
      exp_aq.push_back(use_exp ? exp_next : nxt);
      tick();
      retire = 1'b0;
      Branch = 1'b0;
      Jump   = 1'b0;
      Zero   = 1'b0;
   endtask

   task automatic mid_wait_reset;
      bit hs;
      hs = 0;
      imem_req_ready = 1'b1;
      for (int k = 0; k < 20 && !hs; k++) begin
         @(negedge CLK);
         hs = imem_req_valid && imem_req_ready;
         tick();
      end
      imem_req_ready = 1'b0;
      tick();
      Reset_L = 1'b0;
      tick();
      tick();
      exp_aq.delete();
      exp_iq.delete();
      m_pc = RST_PC;
      m_fc = '0;
      m_rc = '0;
      exp_aq.push_back(RST_PC);
      Reset_L        = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      imem_rsp_valid = 1'b0;
   endtask

   // monitor: pops the scoreboard whenever the DUT presents a request or a new instruction
   initial begin
      bit          prev_iv;
      logic [31:0] held, held_pc;
      exp_t        e;
      prev_iv = 0;
      held    = '0;
      held_pc = '0;
      forever begin
         @(negedge CLK);
         if (!Reset_L) begin
            if (rst_seen) begin
               chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
               chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
               chk("rst_instruction", Instruction, 32'd0);
               chk("rst_pc", PC, RST_PC);
               chk("rst_fetch_count", fetch_count, 32'd0);
               chk("rst_redirect_count", redirect_count, 32'd0);
               held    = '0;
               prev_iv = 0;
            end
         end else begin
            if (imem_req_valid) begin
               if (exp_aq.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
               end else begin
                  chk("imem_addr", imem_addr, exp_aq[0]);
                  if (imem_req_ready)
                     void'(exp_aq.pop_front());
               end
            end
            if (instr_valid && !prev_iv) begin
               if (exp_iq.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL issue_unexpected: got instr %h expected none", Instruction);
               end else begin
                  e = exp_iq.pop_front();
                  chk("instruction", Instruction, e.instr);
                  chk("opcode", {26'b0, Opcode}, {26'b0, e.instr[31:26]});
                  chk("issue_pc", PC, e.pc);
                  chk("fetch_count", fetch_count, e.fc);
                  chk("redirect_count", redirect_count, e.rc);
                  held    = e.instr;
                  held_pc = e.pc;
               end
               if (lat_check) begin
                  chk("issue_latency", 32'(cyc - rel_cyc + 1), 32'd3);
                  lat_check = 0;
               end
            end else begin
               chk("instr_hold", Instruction, held);
               if (instr_valid)
                  chk("pc_hold", PC, held_pc);
            end
            prev_iv = instr_valid;
         end
      end
   end

   initial begin
      #100000;
      n_err++;
      $display("FAIL watchdog: run did not complete, expected finish before 100000 time units");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      Reset_L        = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      Branch         = 1'b0;
      Jump           = 1'b0;
      Zero           = 1'b0;
      retire         = 1'b0;

      dir[0]  = '{{OP_J, 26'h40},                      32'h0000_0100, 1'b0, 1'b1, 1'b0, 0};
      dir[1]  = '{{OP_BEQ, 5'd1, 5'd2, 16'hFFFF},      32'h0000_0100, 1'b1, 1'b0, 1'b1, 1};
      dir[2]  = '{{OP_BEQ, 5'd1, 5'd2, 16'hFFFF},      32'h0000_0104, 1'b1, 1'b0, 1'b0, 0};
      dir[3]  = '{{OP_J, 26'h40},                      32'h0000_0100, 1'b0, 1'b1, 1'b0, 5};
      dir[4]  = '{32'h0123_4820,                       32'h0000_0104, 1'b0, 1'b0, 1'b0, 2};
      dir[5]  = '{{OP_BEQ, 5'd3, 5'd3, 16'h8000},      32'hFFFE_0108, 1'b1, 1'b0, 1'b1, 0};
      dir[6]  = '{{OP_J, 26'h3FF_FFFF},                32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 0};
      dir[7]  = '{32'h0000_0020,                       32'h0000_0000, 1'b0, 1'b0, 1'b0, 0};
      dir[8]  = '{{OP_J, 26'h3FF_FFFF},                32'h0FFF_FFFC, 1'b0, 1'b1, 1'b0, 0};
      dir[9]  = '{{OP_BEQ, 5'd0, 5'd0, 16'h0000},      32'h1000_0000, 1'b1, 1'b0, 1'b1, 0};
      dir[10] = '{{OP_J, 26'h40},                      32'h1000_0100, 1'b1, 1'b1, 1'b1, 0};

      tick();
      tick();
      m_pc = RST_PC;
      m_fc = '0;
      m_rc = '0;
      exp_aq.push_back(RST_PC);
      Reset_L   = 1'b1;
      rel_cyc   = cyc;
      lat_check = 1;

      for (int i = 0; i < 11; i++)
         do_step(dir[i].instr, dir[i].b, dir[i].j, dir[i].z, dir[i].stall,
                 (i == 0) ? 0 : 1, (i == 0) ? 0 : 2, 1'b1, dir[i].nxt);

      mid_wait_reset();

      for (int i = 0; i < 150; i++)
         do_step($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), -1, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'b0, 32'h0);

      repeat (4) tick();
      chk("issue_queue_drained", 32'(exp_iq.size()), 32'd0);
      chk("addr_queue_pending", 32'(exp_aq.size()), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
